// File: rtl/frogger_pkg.sv
// ============================================================================
// Module      : frogger_pkg
// Description : Shared screen constants, coordinate type and collision-checker
//               state encoding for the frogger datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frogger_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef logic [10:0] coord_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_REPORT = 2'd2
   } collide_state_t;

endpackage

`default_nettype wire

// File: rtl/span_overlap.sv
// ============================================================================
// Module      : span_overlap
// Description : Combinational 1-D interval overlap test of [a_lo, a_lo+a_len-1]
//               against [b_lo, b_lo+b_len-1]; both lengths must be non-zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module span_overlap (
   input  logic [11:0] a_lo,
   input  logic [11:0] a_len,
   input  logic [11:0] b_lo,
   input  logic [11:0] b_len,
   output logic        overlap
);

   logic [11:0] w_a_hi;
   logic [11:0] w_b_hi;

   assign w_a_hi  = a_lo + a_len - 12'd1;
   assign w_b_hi  = b_lo + b_len - 12'd1;
   assign overlap = (b_lo <= w_a_hi) && (a_lo <= w_b_hi);

endmodule

`default_nettype wire

// File: rtl/car_row_collide.sv
// ============================================================================
// Module      : car_row_collide
// Description : Per-lane collision checker; snapshots one lane and the frog,
//               scans active cars one per cycle, reports via valid/ack.
//               Optional macro CAR_WRAP_EN adds the right-edge wrapped segment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module car_row_collide
   import frogger_pkg::*;
#(
   parameter int CAR_WIDTH  = 48,
   parameter int CAR_HEIGHT = 32,
   parameter int FROG_SIZE  = 32,
   parameter int SCREEN_W   = frogger_pkg::SCREEN_W
) (
   input  logic             frame_clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [3:0][10:0] Car_Start_X,
   input  logic [1:0]       Number_Cars,
   input  coord_t           CarY,
   input  coord_t           FrogX,
   input  coord_t           FrogY,
   output logic             Busy,
   output logic             Hit_Valid,
   output logic             Hit,
   output logic [1:0]       Hit_Index,
   input  logic             Hit_Ack,
   output logic [7:0]       Hit_Count
);

   localparam logic [11:0] C_CAR_W  = 12'(CAR_WIDTH);
   localparam logic [11:0] C_CAR_H  = 12'(CAR_HEIGHT);
   localparam logic [11:0] C_FROG   = 12'(FROG_SIZE);

   if (CAR_WIDTH > SCREEN_W) begin : g_bad_width
      $error("CAR_WIDTH must not exceed SCREEN_W");
   end

   collide_state_t   state_q, state_d;
   logic [2:0]       scan_q, scan_d;
   logic [1:0]       last_q, last_d;
   logic [3:0][10:0] carx_q, carx_d;
   coord_t           cary_q, cary_d;
   coord_t           frogx_q, frogx_d;
   coord_t           frogy_q, frogy_d;
   logic             ov_q, ov_d;
   logic             ov_vld_q, ov_vld_d;
   logic [1:0]       ov_idx_q, ov_idx_d;
   logic             hit_q, hit_d;
   logic [1:0]       hit_idx_q, hit_idx_d;
   logic [7:0]       hit_count_q, hit_count_d;

   logic [11:0]      w_car_x;
   logic             w_x_ov;
   logic             w_y_ov;
   logic             w_wrap_ov;
   logic             w_car_ov;

   assign w_car_x = {1'b0, carx_q[scan_q[1:0]]};

   span_overlap u_x_ov (
      .a_lo    (w_car_x),
      .a_len   (C_CAR_W),
      .b_lo    ({1'b0, frogx_q}),
      .b_len   (C_FROG),
      .overlap (w_x_ov)
   );

   span_overlap u_y_ov (
      .a_lo    ({1'b0, cary_q}),
      .a_len   (C_CAR_H),
      .b_lo    ({1'b0, frogy_q}),
      .b_len   (C_FROG),
      .overlap (w_y_ov)
   );

`ifdef CAR_WRAP_EN
   logic [11:0] w_car_end;
   logic [11:0] w_wrap_len;
   logic        w_wrap_act;
   logic        w_wrap_x_ov;

   // Portion of the car beyond the right edge reappears starting at X=0.
   assign w_car_end  = w_car_x + C_CAR_W;
   assign w_wrap_act = w_car_end > 12'(SCREEN_W);
   assign w_wrap_len = w_car_end - 12'(SCREEN_W);

   span_overlap u_wrap_ov (
      .a_lo    (12'd0),
      .a_len   (w_wrap_len),
      .b_lo    ({1'b0, frogx_q}),
      .b_len   (C_FROG),
      .overlap (w_wrap_x_ov)
   );

   assign w_wrap_ov = w_wrap_act & w_wrap_x_ov;
`else
   assign w_wrap_ov = 1'b0;
`endif

   assign w_car_ov = (w_x_ov | w_wrap_ov) & w_y_ov;

   always_comb begin
      state_d     = state_q;
      scan_d      = scan_q;
      last_d      = last_q;
      carx_d      = carx_q;
      cary_d      = cary_q;
      frogx_d     = frogx_q;
      frogy_d     = frogy_q;
      ov_d        = ov_q;
      ov_vld_d    = ov_vld_q;
      ov_idx_d    = ov_idx_q;
      hit_d       = hit_q;
      hit_idx_d   = hit_idx_q;
      hit_count_d = hit_count_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               carx_d    = Car_Start_X;
               last_d    = Number_Cars;
               cary_d    = CarY;
               frogx_d   = FrogX;
               frogy_d   = FrogY;
               scan_d    = 3'd0;
               ov_vld_d  = 1'b0;
               hit_d     = 1'b0;
               hit_idx_d = 2'd0;
               state_d   = ST_SCAN;
            end
         end

         ST_SCAN: begin
            // Compare result is registered first, so the last car's result is
            // folded in one cycle after it is tested; this sets latency N+1.
            if (ov_vld_q && ov_q && !hit_q) begin
               hit_d     = 1'b1;
               hit_idx_d = ov_idx_q;
            end
            if (scan_q <= {1'b0, last_q}) begin
               ov_d     = w_car_ov;
               ov_idx_d = scan_q[1:0];
               ov_vld_d = 1'b1;
               scan_d   = scan_q + 3'd1;
            end else begin
               ov_vld_d = 1'b0;
               state_d  = ST_REPORT;
            end
         end

         ST_REPORT: begin
            if (Hit_Ack) begin
               if (hit_q && (hit_count_q != 8'hFF)) begin
                  hit_count_d = hit_count_q + 8'd1;
               end
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         scan_q      <= 3'd0;
         last_q      <= 2'd0;
         carx_q      <= '0;
         cary_q      <= '0;
         frogx_q     <= '0;
         frogy_q     <= '0;
         ov_q        <= 1'b0;
         ov_vld_q    <= 1'b0;
         ov_idx_q    <= 2'd0;
         hit_q       <= 1'b0;
         hit_idx_q   <= 2'd0;
         hit_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         scan_q      <= scan_d;
         last_q      <= last_d;
         carx_q      <= carx_d;
         cary_q      <= cary_d;
         frogx_q     <= frogx_d;
         frogy_q     <= frogy_d;
         ov_q        <= ov_d;
         ov_vld_q    <= ov_vld_d;
         ov_idx_q    <= ov_idx_d;
         hit_q       <= hit_d;
         hit_idx_q   <= hit_idx_d;
         hit_count_q <= hit_count_d;
      end
   end

   assign Busy      = (state_q != ST_IDLE);
   assign Hit_Valid = (state_q == ST_REPORT);
   assign Hit       = hit_q;
   assign Hit_Index = hit_idx_q;
   assign Hit_Count = hit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_car_row_collide.sv
// ============================================================================
// Module      : tb_car_row_collide
// Description : Directed self-checking bench for car_row_collide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_car_row_collide;

   logic             frame_clk;
   logic             Reset;
   logic             Start;
   logic [3:0][10:0] Car_Start_X;
   logic [1:0]       Number_Cars;
   logic [10:0]      CarY;
   logic [10:0]      FrogX;
   logic [10:0]      FrogY;
   logic             Busy;
   logic             Hit_Valid;
   logic             Hit;
   logic [1:0]       Hit_Index;
   logic             Hit_Ack;
   logic [7:0]       Hit_Count;

   int total = 0;
   int bad   = 0;
   int exp_count = 0;

   car_row_collide dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .Start       (Start),
      .Car_Start_X (Car_Start_X),
      .Number_Cars (Number_Cars),
      .CarY        (CarY),
      .FrogX       (FrogX),
      .FrogY       (FrogY),
      .Busy        (Busy),
      .Hit_Valid   (Hit_Valid),
      .Hit         (Hit),
      .Hit_Index   (Hit_Index),
      .Hit_Ack     (Hit_Ack),
      .Hit_Count   (Hit_Count)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic step();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] n, input logic [3:0][10:0] cars,
                           input logic [10:0] cy, input logic [10:0] fx,
                           input logic [10:0] fy);
      Number_Cars = n;
      Car_Start_X = cars;
      CarY        = cy;
      FrogX       = fx;
      FrogY       = fy;
      Start       = 1'b1;
      step();
      Start       = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (cyc < 20) begin
         step();
         cyc++;
         if (Hit_Valid) break;
      end
   endtask

   task automatic do_ack();
      Hit_Ack = 1'b1;
      step();
      Hit_Ack = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      step();
      step();
      total++;
      if ({Busy, Hit_Valid, Hit, Hit_Index, Hit_Count} !== 13'd0) begin
         bad++;
         $display("FAIL reset_values: got busy=%0b valid=%0b hit=%0b idx=%0d cnt=%0d want all 0",
                  Busy, Hit_Valid, Hit, Hit_Index, Hit_Count);
      end
      Reset = 1'b0;
      step();
   endtask

   task automatic test_miss_timing();
      int cyc;
      do_start(2'd3, {11'd480, 11'd320, 11'd160, 11'd0}, 11'd100, 11'd600, 11'd100);
      total++;
      if (Busy !== 1'b1) begin
         bad++;
         $display("FAIL miss_busy: got %0b want 1", Busy);
      end
      wait_valid(cyc);
      total++;
      if (cyc !== 5) begin
         bad++;
         $display("FAIL miss_latency: got %0d cycles want 5", cyc);
      end
      total++;
      if ({Hit, Hit_Index} !== 3'b000) begin
         bad++;
         $display("FAIL miss_result: got hit=%0b idx=%0d want hit=0 idx=0", Hit, Hit_Index);
      end
      do_ack();
      total++;
      if ({Hit_Valid, Busy} !== 2'b00 || Hit_Count !== 8'(exp_count)) begin
         bad++;
         $display("FAIL miss_ack: got valid=%0b busy=%0b cnt=%0d want 0 0 %0d",
                  Hit_Valid, Busy, Hit_Count, exp_count);
      end
   endtask

   task automatic test_lowest_index();
      int cyc;
      do_start(2'd3, {11'd400, 11'd190, 11'd180, 11'd0}, 11'd100, 11'd200, 11'd110);
      wait_valid(cyc);
      total++;
      if (cyc !== 5 || Hit !== 1'b1 || Hit_Index !== 2'd1) begin
         bad++;
         $display("FAIL lowest_index: got cyc=%0d hit=%0b idx=%0d want 5 1 1", cyc, Hit, Hit_Index);
      end
      do_ack();
      exp_count++;
      total++;
      if (Hit_Count !== 8'(exp_count)) begin
         bad++;
         $display("FAIL lowest_count: got %0d want %0d", Hit_Count, exp_count);
      end
   endtask

   task automatic test_handshake_snapshot();
      int cyc;
      int stable_bad;
      do_start(2'd3, {11'd400, 11'd190, 11'd180, 11'd0}, 11'd100, 11'd200, 11'd110);
      step();
      FrogX       = 11'd600;
      FrogY       = 11'd300;
      Number_Cars = 2'd0;
      Car_Start_X = '0;
      wait_valid(cyc);
      total++;
      if (cyc !== 4 || Hit !== 1'b1 || Hit_Index !== 2'd1) begin
         bad++;
         $display("FAIL snapshot: got cyc=%0d hit=%0b idx=%0d want 4 1 1", cyc, Hit, Hit_Index);
      end
      stable_bad = 0;
      for (int i = 0; i < 10; i++) begin
         Start = (i == 4);
         step();
         if (Hit_Valid !== 1'b1 || Hit !== 1'b1 || Hit_Index !== 2'd1) stable_bad++;
      end
      Start = 1'b0;
      total++;
      if (stable_bad !== 0) begin
         bad++;
         $display("FAIL hold_stable: got %0d unstable cycles want 0", stable_bad);
      end
      do_ack();
      exp_count++;
      total++;
      if (Busy !== 1'b0 || Hit_Valid !== 1'b0 || Hit_Count !== 8'(exp_count)) begin
         bad++;
         $display("FAIL hold_ack: got busy=%0b valid=%0b cnt=%0d want 0 0 %0d",
                  Busy, Hit_Valid, Hit_Count, exp_count);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      do_start(2'd0, {11'd0, 11'd0, 11'd0, 11'd0}, 11'd100, 11'd10, 11'd100);
      wait_valid(cyc);
      do_ack();
      exp_count++;
      Start = 1'b1;
      step();
      Start = 1'b0;
      total++;
      if (Busy !== 1'b1) begin
         bad++;
         $display("FAIL b2b_start: got busy=%0b want 1", Busy);
      end
      wait_valid(cyc);
      total++;
      if (cyc !== 2 || Hit !== 1'b1 || Hit_Index !== 2'd0) begin
         bad++;
         $display("FAIL b2b_result: got cyc=%0d hit=%0b idx=%0d want 2 1 0", cyc, Hit, Hit_Index);
      end
      do_ack();
      exp_count++;
   endtask

   task automatic test_ack_held();
      int cyc;
      Hit_Ack = 1'b1;
      step();
      do_start(2'd1, {11'd0, 11'd0, 11'd300, 11'd0}, 11'd100, 11'd290, 11'd100);
      wait_valid(cyc);
      total++;
      if (cyc !== 3 || Hit !== 1'b1 || Hit_Index !== 2'd1) begin
         bad++;
         $display("FAIL held_result: got cyc=%0d hit=%0b idx=%0d want 3 1 1", cyc, Hit, Hit_Index);
      end
      step();
      Hit_Ack = 1'b0;
      exp_count++;
      total++;
      if (Hit_Valid !== 1'b0 || Busy !== 1'b0 || Hit_Count !== 8'(exp_count)) begin
         bad++;
         $display("FAIL held_accept: got valid=%0b busy=%0b cnt=%0d want 0 0 %0d",
                  Hit_Valid, Busy, Hit_Count, exp_count);
      end
   endtask

   task automatic test_y_boundary();
      int cyc;
      do_start(2'd0, {11'd0, 11'd0, 11'd0, 11'd0}, 11'd100, 11'd10, 11'd140);
      wait_valid(cyc);
      total++;
      if (Hit !== 1'b0) begin
         bad++;
         $display("FAIL y_miss: got hit=%0b want 0", Hit);
      end
      do_ack();
      do_start(2'd0, {11'd0, 11'd0, 11'd0, 11'd0}, 11'd100, 11'd10, 11'd131);
      wait_valid(cyc);
      total++;
      if (Hit !== 1'b1 || Hit_Index !== 2'd0) begin
         bad++;
         $display("FAIL y_edge_hit: got hit=%0b idx=%0d want 1 0", Hit, Hit_Index);
      end
      do_ack();
      exp_count++;
   endtask

   task automatic test_wrap();
      int cyc;
      logic exp_hit;
`ifdef CAR_WRAP_EN
      exp_hit = 1'b1;
`else
      exp_hit = 1'b0;
`endif
      do_start(2'd0, {11'd0, 11'd0, 11'd0, 11'd620}, 11'd100, 11'd0, 11'd100);
      wait_valid(cyc);
      total++;
      if (Hit !== exp_hit) begin
         bad++;
         $display("FAIL wrap: got hit=%0b want %0b", Hit, exp_hit);
      end
      do_ack();
      if (exp_hit) exp_count++;
      total++;
      if (Hit_Count !== 8'(exp_count)) begin
         bad++;
         $display("FAIL wrap_count: got %0d want %0d", Hit_Count, exp_count);
      end
   endtask

   task automatic test_reset_midscan();
      do_start(2'd3, {11'd400, 11'd190, 11'd180, 11'd0}, 11'd100, 11'd200, 11'd110);
      step();
      Reset = 1'b1;
      #1;
      total++;
      if (Busy !== 1'b0 || Hit_Valid !== 1'b0 || Hit_Count !== 8'd0 || Hit !== 1'b0) begin
         bad++;
         $display("FAIL reset_midscan: got busy=%0b valid=%0b hit=%0b cnt=%0d want 0 0 0 0",
                  Busy, Hit_Valid, Hit, Hit_Count);
      end
      step();
      Reset = 1'b0;
      exp_count = 0;
      step();
   endtask

   task automatic test_saturation();
      int cyc;
      for (int i = 0; i < 260; i++) begin
         do_start(2'd0, {11'd0, 11'd0, 11'd0, 11'd0}, 11'd100, 11'd10, 11'd100);
         wait_valid(cyc);
         do_ack();
         if (exp_count < 255) exp_count++;
         if (i == 253) begin
            total++;
            if (Hit_Count !== 8'd254) begin
               bad++;
               $display("FAIL sat_254: got %0d want 254", Hit_Count);
            end
         end
      end
      total++;
      if (Hit_Count !== 8'(exp_count) || Hit_Count !== 8'd255) begin
         bad++;
         $display("FAIL sat_255: got %0d want 255", Hit_Count);
      end
   endtask

   initial begin
      Reset       = 1'b1;
      Start       = 1'b0;
      Hit_Ack     = 1'b0;
      Car_Start_X = '0;
      Number_Cars = 2'd0;
      CarY        = '0;
      FrogX       = '0;
      FrogY       = '0;
      test_reset();
      test_miss_timing();
      test_lowest_index();
      test_handshake_snapshot();
      test_back_to_back();
      test_ack_held();
      test_y_boundary();
      test_wrap();
      test_reset_midscan();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
